// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / tick generator.
// Each channel has a shadowed terminal count and mode applied at period boundaries.
module clk_div_multi #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int AW      = 2,
  parameter int DEF_DIV = 9999
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  input  logic              sync_restart,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_div;
    logic [CNT_W-1:0] sh_div;
    logic             act_mode;
    logic             sh_mode;
    logic             pend;
    logic             clk_q;
    logic             tick_q;
    logic             wr;
    logic             term;
    logic             apply;
    logic             mode_chg;

    // Addresses at or above NUM_CH never match any channel, so such writes are dropped.
    assign wr       = cfg_we && (cfg_addr == AW'(i));
    assign term     = en[i] && (cnt >= act_div);
    assign apply    = pend && (sync_restart || !en[i] || term);
    assign mode_chg = apply && (sh_mode != act_mode);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt      <= '0;
        act_div  <= CNT_W'(DEF_DIV);
        sh_div   <= CNT_W'(DEF_DIV);
        act_mode <= 1'b0;
        sh_mode  <= 1'b0;
        pend     <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        if (wr) begin
          sh_div  <= cfg_div;
          sh_mode <= cfg_mode;
        end
        // Apply consumes the shadow as it stood before this edge; a same-edge write re-arms pending.
        pend <= (pend && !apply) || wr;
        if (apply) begin
          act_div  <= sh_div;
          act_mode <= sh_mode;
        end
        if (sync_restart) begin
          cnt    <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
        end else if (en[i]) begin
          if (term) begin
            cnt    <= '0;
            tick_q <= 1'b1;
            if (mode_chg)      clk_q <= 1'b0;
            else if (act_mode) clk_q <= 1'b1;
            else               clk_q <= ~clk_q;
          end else begin
            cnt    <= cnt + 1'b1;
            tick_q <= 1'b0;
            if (act_mode) clk_q <= 1'b0;
          end
        end else begin
          tick_q <= 1'b0;
          if (act_mode || mode_chg) clk_q <= 1'b0;
        end
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
    assign pending[i] = pend;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised, multi-channel programmable clock divider and tick generator. It replaces the fixed single-channel toggle divider (terminal count 9999, output period of 20000 cycles).
- Each channel has a runtime-loadable terminal count, a toggle or pulse output mode, an enable, and a shadow register so new settings take effect glitch-free at a period boundary.
- Sits next to the system clock/reset logic and feeds slow strobes and slow clocks to timers, scan logic and peripherals.

Parameters:
- NUM_CH, 4: number of independent divider channels (1..16).
- CNT_W, 16: counter and divisor width in bits.
- AW, 2: cfg_addr width. Must be at least clog2(NUM_CH), minimum 1.
- DEF_DIV, 9999: terminal count loaded at reset. Must fit in CNT_W bits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  NUM_CH  per-channel count enable.
- cfg_we  in  1  single-cycle write strobe for configuration.
- cfg_addr  in  AW  channel select for cfg_we.
- cfg_div  in  CNT_W  new terminal count D.
- cfg_mode  in  1  new mode: 0 = toggle (square wave), 1 = pulse.
- sync_restart  in  1  phase-aligns all channels.
- clk_out  out  NUM_CH  divided output, registered.
- tick  out  NUM_CH  one-cycle strobe at terminal count, registered.
- pending  out  NUM_CH  shadow configuration not yet applied.

Behaviour:
- Reset (async, rst_n=0), per channel:
  - cnt=0.
  - active D = shadow D = DEF_DIV.
  - active mode = shadow mode = 0.
  - pending=0, clk_out=0, tick=0.
- Terminal condition: en[i]=1 and cnt >= active D. Using ">=" rather than "==" makes the channel safe when a smaller D is applied mid-count. cnt never overflows.
- Clock edge with en[i]=1:
  - If terminal: cnt <= 0 and tick <= 1.
    - Mode 0: clk_out toggles.
    - Mode 1: clk_out <= 1.
  - Else: cnt <= cnt+1, tick <= 0.
    - Mode 0: clk_out holds.
    - Mode 1: clk_out <= 0.
- Resulting timing:
  - tick period is D+1 cycles.
  - Mode 0 clk_out period is 2(D+1) cycles at 50% duty.
  - Mode 1 clk_out equals tick.
- D=0: tick is high every cycle. Mode 0 clk_out = clk/2.
- Clock edge with en[i]=0:
  - cnt and clk_out hold; tick <= 0.
  - Exception: in mode 1, clk_out <= 0.
  - On re-enable, counting resumes from the held cnt.
- Config write: cfg_we=1 with cfg_addr < NUM_CH loads shadow D/mode and sets pending.
  - cfg_addr >= NUM_CH: the write is ignored and no state changes.
  - A second write before apply overwrites the shadow (last write wins).
- Apply (shadow -> active, pending <= 0) happens at:
  - the terminal edge of an enabled channel, or
  - the first edge at which pending=1 and en[i]=0, or
  - a sync_restart edge.
- Apply uses the shadow contents registered before the edge. A write in the same cycle as a terminal edge is therefore applied at the next terminal.
- On apply with a mode change, clk_out <= 0 at that edge. tick still follows the terminal rule. The new mode governs from the next edge.
- sync_restart=1 (priority over everything except reset), all channels:
  - cnt <= 0, clk_out <= 0, tick <= 0.
  - Pending shadows are applied.
  - A cfg_we in the same cycle still loads the shadow and sets pending.
- Reset asserted mid-operation returns every channel to reset values immediately, discarding pending configuration. Counting restarts from 0 on the first edge after release.
- Channels are fully independent apart from shared cfg inputs and sync_restart.

Test Plan:
- Reset release, en=0001, defaults → tick[0] on cycle 10000 after release, then every 10000 cycles. clk_out[0] rises at 10000 and falls at 20000. pending=0.
- ch1 disabled: write D=3, mode 0 → pending[1] is 1 for one cycle, then applied. With en[1]=1, tick[1] every 4 cycles and clk_out[1] period 8.
- ch2 running with D=9: write D=4, mode 1 at cnt=2 → current period completes (tick at cnt=9), then clk_out[2]=tick[2] every 5 cycles. clk_out forced 0 at the apply edge.
- ch3 D=9, disabled at cnt=7: write D=2, then re-enable → terminal on the first enabled edge (7>=2), after which tick every 3 cycles. Write D=0 → tick every cycle, clk_out[3]=clk/2.
- sync_restart pulse with channels at differing phases → all cnt=0 and clk_out=0. Equal-D channels then tick on identical cycles. A pending write to ch0 is applied at the restart edge.
- cfg_addr=3 with NUM_CH=3 → no state change. rst_n dropped mid-period with pending=1 → outputs 0 immediately, DEF_DIV restored, pending cleared.
